// File: rtl/rbot_moves_pkg.sv
// Shared definitions for the move dispatch path.
//   - move_t and the move code constants (R..Di = 2..13, MOVE_NONE = 0)
//   - inverse_of(): every valid move's inverse is the code with bit 0 flipped
//   - is_valid_move(): true for codes 2..13
//   - err_code_e: error_code encodings
//   - state_e: dispatcher FSM states (exported on dbg_state)
package rbot_moves_pkg;

  typedef logic [3:0] move_t;

  localparam move_t MOVE_NONE = 4'd0;
  localparam move_t MOVE_R    = 4'd2;
  localparam move_t MOVE_RI   = 4'd3;
  localparam move_t MOVE_U    = 4'd4;
  localparam move_t MOVE_UI   = 4'd5;
  localparam move_t MOVE_F    = 4'd6;
  localparam move_t MOVE_FI   = 4'd7;
  localparam move_t MOVE_L    = 4'd8;
  localparam move_t MOVE_LI   = 4'd9;
  localparam move_t MOVE_B    = 4'd10;
  localparam move_t MOVE_BI   = 4'd11;
  localparam move_t MOVE_D    = 4'd12;
  localparam move_t MOVE_DI   = 4'd13;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_BAD_CODE = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_READY     = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  function automatic move_t inverse_of(input move_t m);
    return m ^ 4'd1;
  endfunction

  function automatic logic is_valid_move(input move_t m);
    return (m >= MOVE_R) && (m <= MOVE_DI);
  endfunction

endpackage

// File: rtl/move_queue.sv
// Circular move buffer.
//   clock, reset_n : clock and asynchronous active-low reset (empties the queue)
//   flush          : empty the queue (wins over every other request)
//   push/push_data : append at the tail; ignored when full or when pop_tail is set
//   pop_head       : remove the oldest entry; head shows it
//   pop_tail       : remove the newest entry (inverse cancellation); tail shows it
//   count/full/empty : occupancy
// Only one pop is honoured per cycle; pop_head wins over pop_tail.
module move_queue
  import rbot_moves_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  move_t                      push_data,
  input  logic                       pop_head,
  input  logic                       pop_tail,
  output move_t                      head,
  output move_t                      tail,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  move_t         mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;   // next free slot
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop_head, do_pop_tail;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[head_q];
  assign tail  = mem_q[ptr_dec(tail_q)];

  always_comb begin
    do_pop_head = pop_head && !empty;
    do_pop_tail = pop_tail && !empty && !do_pop_head;
    do_push     = push && !full && !pop_tail;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_pop_head) head_d = ptr_inc(head_q);
      if (do_pop_tail) tail_d = ptr_dec(tail_q);
      if (do_push)     tail_d = ptr_inc(tail_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop_head) - CW'(do_pop_tail);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: it is only read while count_q says it is valid.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[tail_q] <= push_data;
  end

endmodule

// File: rtl/move_dispatcher.sv
// Move dispatcher between the solver and the stepper driver.
//   clock, reset_n     : 25 MHz clock, asynchronous active-low reset
//   moves_in           : packed move codes, nibble i = [4i+3:4i]; must be held
//                        stable for the MAX_MOVES cycles of a load
//   load/go/abort      : one-cycle command pulses
//   next_move          : move code for the stepper, stable until the next start
//   move_start         : one-cycle start pulse to the stepper
//   move_done          : stepper completion, rising edge counts
//   busy               : high in LOAD/START/WAIT_DONE/SETTLE
//   done               : one-cycle pulse when the queue drains normally
//   queued_count       : entries in the queue
//   executed_count     : moves completed since the last load from IDLE
//   error/error_code   : sticky error flag, code of the latest error
//   dbg_state          : current FSM state (state_e encoding)
//
// Stepper handshake: move_start pulses high for one cycle with next_move
// already valid; the stepper signals completion with a low-to-high
// transition on move_done. A move_done level that is already high when the
// dispatcher starts waiting is not a completion; only a new rising edge is.
module move_dispatcher
  import rbot_moves_pkg::*;
#(
  parameter int MAX_MOVES       = 50,
  parameter int DEPTH           = 64,
  parameter int SETTLE_CYCLES   = 250000,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter int CANCEL_INVERSES = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [4*MAX_MOVES-1:0] moves_in,
  input  logic                   load,
  input  logic                   go,
  input  logic                   abort,
  output logic [3:0]             next_move,
  output logic                   move_start,
  input  logic                   move_done,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             queued_count,
  output logic [7:0]             executed_count,
  output logic                   error,
  output logic [1:0]             error_code,
  output logic [2:0]             dbg_state
);

  localparam int IW      = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int QCW     = $clog2(DEPTH + 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;          // nibble being scanned in LOAD
  logic [CW-1:0] cnt_q, cnt_d;          // watchdog in WAIT_DONE, settle timer in SETTLE
  move_t         next_move_q, next_move_d;
  logic          move_start_q, move_start_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [7:0]    exec_q, exec_d;
  logic          error_q, error_d;
  err_code_e     err_code_q, err_code_d;
  logic          abort_pend_q, abort_pend_d;
  logic          md_q, md_prev_q;
  logic          done_rise;

  move_t          nib;
  logic           q_flush, q_push, q_pop_head, q_pop_tail;
  move_t          q_head, q_tail;
  logic [QCW-1:0] q_count;
  logic           q_full, q_empty;

  move_queue #(.DEPTH(DEPTH)) u_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (q_flush),
    .push      (q_push),
    .push_data (nib),
    .pop_head  (q_pop_head),
    .pop_tail  (q_pop_tail),
    .head      (q_head),
    .tail      (q_tail),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign nib       = moves_in[{idx_q, 2'b00} +: 4];
  assign done_rise = md_q && !md_prev_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    next_move_d  = next_move_q;
    move_start_d = 1'b0;
    done_d       = 1'b0;
    exec_d       = exec_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    abort_pend_d = abort_pend_q;
    q_flush      = 1'b0;
    q_push       = 1'b0;
    q_pop_head   = 1'b0;
    q_pop_tail   = 1'b0;

    case (state_q)
      // The queue is always empty here, so go has nothing to do.
      ST_IDLE: begin
        if (load) begin
          state_d    = ST_LOAD;
          idx_d      = IW'(MAX_MOVES - 1);
          q_flush    = 1'b1;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          exec_d     = '0;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          q_flush = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (is_valid_move(nib)) begin
            if ((CANCEL_INVERSES != 0) && !q_empty && (q_tail == inverse_of(nib))) begin
              q_pop_tail = 1'b1;
            end else if (q_full) begin
              error_d    = 1'b1;
              err_code_d = ERR_OVERFLOW;
            end else begin
              q_push = 1'b1;
            end
          end else if (nib != MOVE_NONE) begin
            error_d    = 1'b1;
            err_code_d = ERR_BAD_CODE;
          end
          if (idx_q == '0) state_d = ST_READY;
          else             idx_d   = idx_q - 1'b1;
        end
      end

      ST_READY: begin
        if (abort) begin
          q_flush = 1'b1;
          state_d = ST_IDLE;
        end else if (load) begin
          // Append: queue, error and counts are kept.
          state_d = ST_LOAD;
          idx_d   = IW'(MAX_MOVES - 1);
        end else if (go) begin
          if (!q_empty) begin
            state_d      = ST_START;
            next_move_d  = q_head;
            move_start_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_START: begin
        if (abort) begin
          q_flush = 1'b1;
          state_d = ST_IDLE;
        end else begin
          q_pop_head   = 1'b1;
          cnt_d        = '0;
          abort_pend_d = 1'b0;
          state_d      = ST_WAIT_DONE;
        end
      end

      // The move in flight cannot be stopped; abort only takes effect once it ends.
      ST_WAIT_DONE: begin
        if (abort) abort_pend_d = 1'b1;
        if (done_rise) begin
          exec_d = (exec_q == 8'hFF) ? exec_q : exec_q + 8'd1;
          if (abort_pend_q || abort) begin
            q_flush      = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          error_d      = 1'b1;
          err_code_d   = ERR_TIMEOUT;
          abort_pend_d = 1'b0;
          if (abort_pend_q || abort) begin
            q_flush = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          q_flush = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          if (!q_empty) begin
            state_d      = ST_START;
            next_move_d  = q_head;
            move_start_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_FAULT: begin
        if (abort) begin
          q_flush = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        q_flush = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_START) ||
             (state_d == ST_WAIT_DONE) || (state_d == ST_SETTLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      next_move_q  <= MOVE_NONE;
      move_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      exec_q       <= '0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      abort_pend_q <= 1'b0;
      md_q         <= 1'b0;
      md_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      next_move_q  <= next_move_d;
      move_start_q <= move_start_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      exec_q       <= exec_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      abort_pend_q <= abort_pend_d;
      md_q         <= move_done;
      md_prev_q    <= md_q;
    end
  end

  assign next_move      = next_move_q;
  assign move_start     = move_start_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign queued_count   = 8'(q_count);
  assign executed_count = exec_q;
  assign error          = error_q;
  assign error_code     = err_code_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_move_dispatcher.sv
module tb_move_dispatcher;

  localparam int MM      = 50;
  localparam int DEPTH   = 8;
  localparam int SETTLE  = 10;
  localparam int TIMEOUT = 1000;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [4*MM-1:0] moves_in = '0;
  logic          load = 1'b0, go = 1'b0, abort = 1'b0, move_done = 1'b0;
  logic [3:0]    next_move;
  logic          move_start, busy, done, error;
  logic [7:0]    queued_count, executed_count;
  logic [1:0]    error_code;
  logic [2:0]    dbg_state;

  always #5 clock = ~clock;

  move_dispatcher #(
    .MAX_MOVES(MM), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT), .CANCEL_INVERSES(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .moves_in(moves_in), .load(load),
    .go(go), .abort(abort), .next_move(next_move), .move_start(move_start),
    .move_done(move_done), .busy(busy), .done(done),
    .queued_count(queued_count), .executed_count(executed_count),
    .error(error), .error_code(error_code), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [3:0] exp_q[$];
  int n_vec = 0, n_bad = 0;
  int cyc = 0, n_starts = 0, done_cnt = 0;
  int last_start = -1, done_at = -1000, stepper_delay = 100;
  bit stepper_en = 1'b1, check_spacing = 1'b0;

  // Reference model of the queue contents and error state
  int   mq[$];
  logic m_err;
  int   m_code;

  function automatic void check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic void model_load(input logic [4*MM-1:0] v);
    int c;
    for (int i = MM - 1; i >= 0; i--) begin
      c = int'(v[4*i +: 4]);
      if (c == 0) continue;
      if (c < 2 || c > 13) begin
        m_err = 1'b1; m_code = 2;
      end else if (mq.size() > 0 && mq[mq.size()-1] == (c ^ 1)) begin
        void'(mq.pop_back());
      end else if (mq.size() == DEPTH) begin
        m_err = 1'b1; m_code = 1;
      end else begin
        mq.push_back(c);
      end
    end
  endfunction

  function automatic logic [4*MM-1:0] rand_vec();
    logic [4*MM-1:0] v;
    int p;
    v = '0;
    for (int i = 0; i < MM; i++) begin
      p = $urandom_range(0, 99);
      if (p < 75)      v[4*i +: 4] = 4'd0;
      else if (p < 90) v[4*i +: 4] = 4'($urandom_range(2, 5));
      else if (p < 97) v[4*i +: 4] = 4'($urandom_range(2, 13));
      else begin
        p = $urandom_range(0, 2);
        v[4*i +: 4] = (p == 0) ? 4'd1 : ((p == 1) ? 4'd14 : 4'd15);
      end
    end
    return v;
  endfunction

  // One negedge: sample outputs, score starts, drive the model stepper.
  task automatic tick();
    logic [3:0] e;
    @(negedge clock);
    cyc++;
    if (reset_n && move_start) begin
      n_starts++;
      if (exp_q.size() == 0) check("start_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("start_code", int'(next_move), int'(e));
      end
      if (check_spacing && last_start >= 0)
        check("start_spacing", cyc - last_start, stepper_delay + SETTLE + 1);
      last_start = cyc;
      if (stepper_en) done_at = cyc + stepper_delay - 1;
    end
    if (reset_n && done) done_cnt++;
    if (cyc == done_at) move_done = 1'b1;
    else if (cyc == done_at + 3) move_done = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [4*MM-1:0] v);
    int n;
    moves_in = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("load_cycles", n, MM);
  endtask

  task automatic do_run(input int exp_exec);
    int dc0, n;
    dc0 = done_cnt;
    last_start = -1;
    go = 1'b1;
    tick();
    go = 1'b0;
    n = 0;
    while (done_cnt == dc0 && n < 200 * (exp_exec + 1) + 200) begin
      n++;
      tick();
    end
    tick();
    tick();
    check("run_done_pulses", done_cnt - dc0, 1);
    check("run_executed", int'(executed_count), exp_exec);
    check("run_unissued", exp_q.size(), 0);
    check("run_queued", int'(queued_count), 0);
    check("run_busy", int'(busy), 0);
  endtask

  task automatic wait_starts(input int target);
    int n;
    n = 0;
    while (n_starts < target && n < 400) begin
      n++;
      tick();
    end
    check("start_seen", n_starts, target);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [4*MM-1:0] moves;
    int              exp_cnt;
    logic            exp_err;
    logic [1:0]      exp_code;
    logic [31:0]     exp_order;   // first move in nibble 0
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [4*MM-1:0] v;
    int s0, dc0;

    tbl[0] = '{200'h2435,              4, 1'b0, 2'd0, 32'h5342};
    tbl[1] = '{200'h234558,            2, 1'b0, 2'd0, 32'h85};
    tbl[2] = '{{50{4'h2}},             8, 1'b1, 2'd1, 32'h22222222};
    tbl[3] = '{200'h214,               2, 1'b1, 2'd2, 32'h42};
    tbl[4] = '{200'h0,                 0, 1'b0, 2'd0, 32'h0};
    tbl[5] = '{{4'hC, 192'h0, 4'hD},   0, 1'b0, 2'd0, 32'h0};

    // Reset state
    tick();
    tick();
    check("rst_next_move", int'(next_move), 0);
    check("rst_move_start", int'(move_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_queued", int'(queued_count), 0);
    check("rst_executed", int'(executed_count), 0);
    check("rst_error", int'(error), 0);
    check("rst_error_code", int'(error_code), 0);
    reset_n = 1'b1;
    tick();

    // Directed table: load, check queue/error, execute, check order
    check_spacing = 1'b1;
    stepper_delay = 100;
    for (int i = 0; i < 6; i++) begin
      do_load(tbl[i].moves);
      check($sformatf("vec%0d_queued", i), int'(queued_count), tbl[i].exp_cnt);
      check($sformatf("vec%0d_error", i), int'(error), int'(tbl[i].exp_err));
      check($sformatf("vec%0d_code", i), int'(error_code), int'(tbl[i].exp_code));
      for (int j = 0; j < tbl[i].exp_cnt; j++) exp_q.push_back(tbl[i].exp_order[4*j +: 4]);
      do_run(tbl[i].exp_cnt);
      check($sformatf("vec%0d_error_sticky", i), int'(error), int'(tbl[i].exp_err));
    end
    check_spacing = 1'b0;

    // Randomized loads (with occasional append) against the reference model
    for (int r = 0; r < 10; r++) begin
      mq.delete();
      m_err = 1'b0;
      m_code = 0;
      v = rand_vec();
      do_load(v);
      model_load(v);
      if ($urandom_range(0, 2) == 0) begin
        v = rand_vec();
        do_load(v);
        model_load(v);
      end
      check($sformatf("rnd%0d_queued", r), int'(queued_count), mq.size());
      check($sformatf("rnd%0d_error", r), int'(error), int'(m_err));
      check($sformatf("rnd%0d_code", r), int'(error_code), m_code);
      foreach (mq[k]) exp_q.push_back(4'(mq[k]));
      stepper_delay = $urandom_range(3, 40);
      do_run(mq.size());
    end
    stepper_delay = 100;

    // Watchdog: stepper never answers
    stepper_en = 1'b0;
    do_load(200'h24);
    exp_q.push_back(4'd2);
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (995) tick();
    check("wd_busy_before", int'(busy), 1);
    check("wd_error_before", int'(error), 0);
    repeat (10) tick();
    check("wd_error", int'(error), 1);
    check("wd_code", int'(error_code), 3);
    check("wd_busy_fault", int'(busy), 0);
    check("wd_state_fault", int'(dbg_state), 6);
    check("wd_queued_fault", int'(queued_count), 1);
    repeat (50) tick();
    check("wd_unissued", exp_q.size(), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("wd_abort_queued", int'(queued_count), 0);
    check("wd_abort_state", int'(dbg_state), 0);
    check("wd_error_sticky", int'(error), 1);
    stepper_en = 1'b1;

    // Abort during WAIT_DONE of move 2 of 4
    do_load(200'h2468);
    check("ab_error_cleared", int'(error), 0);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd4);
    s0 = n_starts;
    dc0 = done_cnt;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_starts(s0 + 2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (150) tick();
    check("ab_executed", int'(executed_count), 2);
    check("ab_state", int'(dbg_state), 0);
    check("ab_busy", int'(busy), 0);
    check("ab_queued", int'(queued_count), 0);
    check("ab_no_done", done_cnt - dc0, 0);
    check("ab_unissued", exp_q.size(), 0);

    // Asynchronous reset in the middle of SETTLE
    do_load(200'h24);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd4);
    s0 = n_starts;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_starts(s0 + 1);
    repeat (104) tick();
    check("ar_executed_before", int'(executed_count), 1);
    check("ar_busy_before", int'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    check("ar_next_move", int'(next_move), 0);
    check("ar_move_start", int'(move_start), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_done", int'(done), 0);
    check("ar_queued", int'(queued_count), 0);
    check("ar_executed", int'(executed_count), 0);
    check("ar_error", int'(error), 0);
    check("ar_code", int'(error_code), 0);
    exp_q.delete();
    done_at = -1000;
    move_done = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("ar_idle_after", int'(dbg_state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
